// File: rtl/addr_seq_counter_pkg.sv
// Shared encodings for the address sequence counter: FSM states and count modes.
package addr_seq_counter_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

endpackage

// File: rtl/addr_seq_counter_if.sv
// Control/status bundle of the address sequence counter; the counter is the slave side.
interface addr_seq_counter_if #(
    parameter int CNT_WIDTH  = 9,
    parameter int PASS_WIDTH = 4
);
    logic                  enable;
    logic                  clear;
    logic                  load;
    logic [CNT_WIDTH-1:0]  load_val;
    logic [CNT_WIDTH-1:0]  limit;
    logic [1:0]            mode;
    logic                  dir;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  tc;
    logic                  done;
    logic [PASS_WIDTH-1:0] pass_cnt;

    modport master (
        output enable, clear, load, load_val, limit, mode, dir,
        input  cnt, tc, done, pass_cnt
    );

    modport slave (
        input  enable, clear, load, load_val, limit, mode, dir,
        output cnt, tc, done, pass_cnt
    );
endinterface

// File: rtl/addr_step_calc.sv
// Combinational boundary detection, stepped value and load clamping for the counter.
module addr_step_calc #(
    parameter int CNT_WIDTH = 9,
    parameter int STEP      = 1
) (
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic [CNT_WIDTH-1:0] limit,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dir,
    output logic                 boundary,
    output logic [CNT_WIDTH-1:0] step_val,
    output logic [CNT_WIDTH-1:0] load_clamped
);
    localparam logic [CNT_WIDTH:0] STEP_EXT = (CNT_WIDTH+1)'(STEP);

    logic [CNT_WIDTH:0] sum_ext;
    logic               over_limit;
    logic               up_bound;
    logic               down_bound;

    // One extra bit keeps cnt+STEP exact, so limit at full scale never aliases to 0.
    assign sum_ext    = {1'b0, cnt} + STEP_EXT;
    assign over_limit = cnt > limit;
    assign up_bound   = sum_ext > {1'b0, limit};
    assign down_bound = {1'b0, cnt} < STEP_EXT;

    // A count left above a freshly lowered limit is a boundary in either direction.
    assign boundary     = over_limit | (dir ? down_bound : up_bound);
    assign step_val     = dir ? (cnt - STEP_EXT[CNT_WIDTH-1:0]) : sum_ext[CNT_WIDTH-1:0];
    assign load_clamped = (load_val > limit) ? limit : load_val;

endmodule

// File: rtl/addr_seq_counter.sv
// Address sequence counter: INIT/RUN/DONE FSM with wrap, saturate and one-shot modes.
module addr_seq_counter
    import addr_seq_counter_pkg::*;
#(
    parameter int CNT_WIDTH  = 9,
    parameter int STEP       = 1,
    parameter int PASS_WIDTH = 4
) (
    input logic              clk,
    input logic              asyn_reset,
    addr_seq_counter_if.slave bus
);
    state_t                state_reg = ST_INIT;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  cnt_reg = '0;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic [PASS_WIDTH-1:0] pass_reg = '0;
    logic [PASS_WIDTH-1:0] pass_next;
    logic                  tc_reg = 1'b0;
    logic                  tc_next;
    logic                  sat_reg = 1'b0;
    logic                  sat_next;

    logic                  boundary;
    logic [CNT_WIDTH-1:0]  step_val;
    logic [CNT_WIDTH-1:0]  load_clamped;
    logic [CNT_WIDTH-1:0]  sat_val;

    addr_step_calc #(
        .CNT_WIDTH (CNT_WIDTH),
        .STEP      (STEP)
    ) u_step_calc (
        .cnt          (cnt_reg),
        .limit        (bus.limit),
        .load_val     (bus.load_val),
        .dir          (bus.dir),
        .boundary     (boundary),
        .step_val     (step_val),
        .load_clamped (load_clamped)
    );

    assign sat_val = bus.dir ? '0 : bus.limit;

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
            pass_reg  <= '0;
            tc_reg    <= 1'b0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pass_reg  <= pass_next;
            tc_reg    <= tc_next;
            sat_reg   <= sat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pass_next  = pass_reg;
        tc_next    = 1'b0;
        sat_next   = sat_reg;

        if (bus.clear) begin
            state_next = ST_INIT;
            cnt_next   = '0;
            pass_next  = '0;
            sat_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN, ST_DONE: begin
                    if (bus.load) begin
                        cnt_next   = load_clamped;
                        state_next = ST_RUN;
                        sat_next   = 1'b0;
                    end else if (bus.enable && (state_reg == ST_RUN)) begin
                        if (!boundary) begin
                            cnt_next = step_val;
                            sat_next = 1'b0;
                        end else begin
                            case (bus.mode)
                                MODE_SAT: begin
                                    // Repeat tc only if the saturation point itself moved.
                                    cnt_next = sat_val;
                                    tc_next  = !sat_reg || (cnt_reg != sat_val);
                                    sat_next = 1'b1;
                                end
                                MODE_ONESHOT: begin
                                    cnt_next   = sat_val;
                                    tc_next    = 1'b1;
                                    state_next = ST_DONE;
                                    sat_next   = 1'b0;
                                end
                                default: begin
                                    cnt_next  = bus.dir ? bus.limit : '0;
                                    pass_next = pass_reg + 1'b1;
                                    tc_next   = 1'b1;
                                    sat_next  = 1'b0;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign bus.cnt      = cnt_reg;
    assign bus.tc       = tc_reg;
    assign bus.done     = (state_reg == ST_DONE);
    assign bus.pass_cnt = pass_reg;

endmodule

// File: tb/tb_addr_seq_counter.sv
// Directed bench: three counters (STEP 1, 2, 3) exercised with hand-computed expectations.
module tb_addr_seq_counter;

    logic clk = 1'b0;
    logic asyn_reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    addr_seq_counter_if #(.CNT_WIDTH(9), .PASS_WIDTH(4)) bus_a ();
    addr_seq_counter_if #(.CNT_WIDTH(9), .PASS_WIDTH(4)) bus_b ();
    addr_seq_counter_if #(.CNT_WIDTH(9), .PASS_WIDTH(4)) bus_c ();

    addr_seq_counter #(.CNT_WIDTH(9), .STEP(1), .PASS_WIDTH(4)) dut_a (
        .clk(clk), .asyn_reset(asyn_reset), .bus(bus_a.slave));
    addr_seq_counter #(.CNT_WIDTH(9), .STEP(2), .PASS_WIDTH(4)) dut_b (
        .clk(clk), .asyn_reset(asyn_reset), .bus(bus_b.slave));
    addr_seq_counter #(.CNT_WIDTH(9), .STEP(3), .PASS_WIDTH(4)) dut_c (
        .clk(clk), .asyn_reset(asyn_reset), .bus(bus_c.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("vector %0d %s: observed %0d expected %0d", vectors, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.enable = 0; bus_a.clear = 0; bus_a.load = 0; bus_a.load_val = '0;
        bus_a.limit = '0; bus_a.mode = 2'b00; bus_a.dir = 0;
        bus_b.enable = 0; bus_b.clear = 0; bus_b.load = 0; bus_b.load_val = '0;
        bus_b.limit = '0; bus_b.mode = 2'b00; bus_b.dir = 0;
        bus_c.enable = 0; bus_c.clear = 0; bus_c.load = 0; bus_c.load_val = '0;
        bus_c.limit = '0; bus_c.mode = 2'b00; bus_c.dir = 0;

        // Reset state
        #12;
        check("rst_cnt",  32'(bus_a.cnt), 0);
        check("rst_tc",   32'(bus_a.tc), 0);
        check("rst_done", 32'(bus_a.done), 0);
        check("rst_pass", 32'(bus_a.pass_cnt), 0);
        @(negedge clk);
        asyn_reset = 0;
        check("init_cnt", 32'(bus_a.cnt), 0);

        // Wrap up, limit 5, STEP 1: 0(INIT),0,1,2,3,4,5,0
        bus_a.limit = 9'd5; bus_a.enable = 1;
        tick();
        check("init_ignores_en", 32'(bus_a.cnt), 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("wrap_cnt_%0d", k), 32'(bus_a.cnt), k % 6);
            check($sformatf("wrap_tc_%0d", k), 32'(bus_a.tc), (k == 6) ? 1 : 0);
        end
        check("wrap_pass", 32'(bus_a.pass_cnt), 1);
        tick();
        check("wrap_tc_drop", 32'(bus_a.tc), 0);
        check("wrap_resume", 32'(bus_a.cnt), 1);

        // clear + load + enable together at cnt=4
        tick(); tick(); tick();
        check("pre_clear_cnt", 32'(bus_a.cnt), 4);
        bus_a.clear = 1; bus_a.load = 1; bus_a.load_val = 9'd3;
        tick();
        check("clr_cnt",  32'(bus_a.cnt), 0);
        check("clr_pass", 32'(bus_a.pass_cnt), 0);
        bus_a.clear = 0; bus_a.load = 0;
        tick();
        check("clr_init_hold", 32'(bus_a.cnt), 0);
        tick();
        check("clr_resume", 32'(bus_a.cnt), 1);

        // Asynchronous reset between edges at cnt=100
        bus_a.enable = 0; bus_a.limit = 9'd200; bus_a.load_val = 9'd100; bus_a.load = 1;
        tick();
        check("load_100", 32'(bus_a.cnt), 100);
        bus_a.load = 0;
        #3 asyn_reset = 1;
        #1;
        check("arst_cnt_now", 32'(bus_a.cnt), 0);
        #1 asyn_reset = 0;
        bus_a.enable = 1;
        tick();
        check("arst_init_hold", 32'(bus_a.cnt), 0);
        tick();
        check("arst_resume", 32'(bus_a.cnt), 1);

        // Load clamp, lowered limit, wrap down, hold, reserved mode
        bus_a.enable = 0; bus_a.load = 1; bus_a.load_val = 9'd300;
        tick();
        check("load_clamp", 32'(bus_a.cnt), 200);
        bus_a.load = 0; bus_a.limit = 9'd50; bus_a.enable = 1;
        tick();
        check("lowered_limit_cnt", 32'(bus_a.cnt), 0);
        check("lowered_limit_tc",  32'(bus_a.tc), 1);
        bus_a.dir = 1; bus_a.limit = 9'd5;
        tick();
        check("wrap_down_cnt",  32'(bus_a.cnt), 5);
        check("wrap_down_pass", 32'(bus_a.pass_cnt), 2);
        bus_a.enable = 0;
        tick();
        check("hold_cnt",  32'(bus_a.cnt), 5);
        check("hold_tc",   32'(bus_a.tc), 0);
        check("hold_pass", 32'(bus_a.pass_cnt), 2);
        bus_a.mode = 2'b11; bus_a.dir = 0; bus_a.enable = 1;
        tick();
        check("reserved_cnt",  32'(bus_a.cnt), 0);
        check("reserved_pass", 32'(bus_a.pass_cnt), 3);

        // Full-scale limit 511 and pass_cnt rollover after 16 wraps
        bus_a.clear = 1; bus_a.enable = 0; bus_a.mode = 2'b00;
        tick();
        check("clr2_pass", 32'(bus_a.pass_cnt), 0);
        bus_a.clear = 0;
        tick();
        bus_a.limit = 9'd511; bus_a.load_val = 9'd510; bus_a.load = 1;
        tick();
        bus_a.load = 0; bus_a.enable = 1;
        tick();
        check("fs_511", 32'(bus_a.cnt), 511);
        tick();
        check("fs_wrap_cnt", 32'(bus_a.cnt), 0);
        check("fs_wrap_tc",  32'(bus_a.tc), 1);
        check("fs_wrap_pass", 32'(bus_a.pass_cnt), 1);
        for (int i = 0; i < 15; i++) begin
            bus_a.enable = 0; bus_a.load = 1; bus_a.load_val = 9'd511;
            tick();
            bus_a.load = 0; bus_a.enable = 1;
            tick();
            check($sformatf("fs_loop_cnt_%0d", i), 32'(bus_a.cnt), 0);
            check($sformatf("fs_loop_pass_%0d", i), 32'(bus_a.pass_cnt), (i + 2) % 16);
        end
        bus_a.enable = 0;

        // One-shot down, STEP 2: 3,1,0 then DONE
        bus_b.limit = 9'd10; bus_b.mode = 2'b10; bus_b.dir = 1;
        bus_b.load_val = 9'd3; bus_b.load = 1;
        tick();
        check("os_load", 32'(bus_b.cnt), 3);
        bus_b.load = 0; bus_b.enable = 1;
        tick();
        check("os_cnt1",  32'(bus_b.cnt), 1);
        check("os_done1", 32'(bus_b.done), 0);
        tick();
        check("os_cnt0",  32'(bus_b.cnt), 0);
        check("os_tc",    32'(bus_b.tc), 1);
        check("os_done",  32'(bus_b.done), 1);
        tick();
        check("os_tc_once",   32'(bus_b.tc), 0);
        check("os_done_hold", 32'(bus_b.done), 1);
        tick();
        check("os_cnt_hold",  32'(bus_b.cnt), 0);
        bus_b.load_val = 9'd8; bus_b.load = 1;
        tick();
        check("os_reload_cnt",  32'(bus_b.cnt), 8);
        check("os_reload_done", 32'(bus_b.done), 0);
        bus_b.load = 0; bus_b.enable = 0;

        // Saturate, STEP 3, limit 7: 0,3,6,7,7 up then 4,1,0,0 down
        bus_c.limit = 9'd7; bus_c.mode = 2'b01; bus_c.dir = 0;
        check("sat_start", 32'(bus_c.cnt), 0);
        bus_c.enable = 1;
        tick(); check("sat_up_3", 32'(bus_c.cnt), 3); check("sat_up_tc3", 32'(bus_c.tc), 0);
        tick(); check("sat_up_6", 32'(bus_c.cnt), 6); check("sat_up_tc6", 32'(bus_c.tc), 0);
        tick(); check("sat_up_7", 32'(bus_c.cnt), 7); check("sat_up_tc7", 32'(bus_c.tc), 1);
        tick(); check("sat_up_7b", 32'(bus_c.cnt), 7); check("sat_up_tc7b", 32'(bus_c.tc), 0);
        check("sat_pass", 32'(bus_c.pass_cnt), 0);
        bus_c.dir = 1;
        tick(); check("sat_dn_4", 32'(bus_c.cnt), 4);
        tick(); check("sat_dn_1", 32'(bus_c.cnt), 1);
        tick(); check("sat_dn_0", 32'(bus_c.cnt), 0); check("sat_dn_tc0", 32'(bus_c.tc), 1);
        tick(); check("sat_dn_0b", 32'(bus_c.cnt), 0); check("sat_dn_tc0b", 32'(bus_c.tc), 0);
        bus_c.enable = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
